stream_source_module: RTL and testbench

STREAM_SOURCE_MODULE -- requirements
Module: stream_source_module

---
 rtl/stream_source_module.sv | 102 ++++++++++
 tb/tb_stream_source_module.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_source_module.sv
// Buffered stream source: a small FIFO feeds a valid/ready output port.
// Beats are framed into fixed-length packets, and accepted beats are counted.
module stream_source_module #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          tx_enable,
  output logic                          stream_out_valid,
  input  logic                          stream_out_ready,
  output logic [DATA_WIDTH-1:0]         stream_out_data,
  output logic                          stream_out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   words_sent
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("PKT_LEN must be at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [BEAT_W-1:0]       beat_cnt;
  logic                    do_wr;
  logic                    do_pop;
  logic [LVL_W-1:0]        level_next;

  // Full is judged on the current level, so a pop in the same cycle never frees a slot early.
  assign wr_ready         = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign do_wr            = wr_valid && wr_ready;
  assign do_pop           = stream_out_valid && stream_out_ready;
  assign level_next       = fifo_level + LVL_W'(do_wr) - LVL_W'(do_pop);

  assign stream_out_valid = (state == SEND);
  assign stream_out_data  = mem[rd_ptr];
  assign stream_out_last  = (beat_cnt == BEAT_W'(PKT_LEN - 1));

  // Storage is deliberately left out of reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      beat_cnt   <= '0;
      words_sent <= '0;
    end else begin
      fifo_level <= level_next;

      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (do_pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        words_sent <= words_sent + 16'd1;
        beat_cnt   <= stream_out_last ? '0 : beat_cnt + BEAT_W'(1);
      end

      // Once valid is raised it is held until the beat is taken.
      case (state)
        IDLE: begin
          if (tx_enable && fifo_level != '0) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (do_pop && (level_next == '0 || !tx_enable)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_source_module.sv
// Directed bench for stream_source_module with default parameters
// (DATA_WIDTH=8, FIFO_DEPTH=4, PKT_LEN=4).
module tb_stream_source_module;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        tx_enable;
  logic        stream_out_valid;
  logic        stream_out_ready;
  logic [7:0]  stream_out_data;
  logic        stream_out_last;
  logic [2:0]  fifo_level;
  logic [15:0] words_sent;

  int n_checks = 0;
  int n_fail   = 0;

  stream_source_module #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .PKT_LEN   (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_data         (wr_data),
    .tx_enable       (tx_enable),
    .stream_out_valid(stream_out_valid),
    .stream_out_ready(stream_out_ready),
    .stream_out_data (stream_out_data),
    .stream_out_last (stream_out_last),
    .fifo_level      (fifo_level),
    .words_sent      (words_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    tx_enable = 1'b0; stream_out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #2;
    n_checks++; if (stream_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", stream_out_valid); end
    n_checks++; if (stream_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", stream_out_last); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    n_checks++; if (words_sent !== 16'd0) begin n_fail++; $display("FAIL reset_words got %0d exp 0", words_sent); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    tx_enable = 1'b1; stream_out_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h11;
    tick();
    wr_valid = 1'b0;
    n_checks++; if (stream_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_n got %b exp 0", stream_out_valid); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL basic_level_n got %0d exp 1", fifo_level); end
    tick();
    n_checks++; if (stream_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_n1 got %b exp 1", stream_out_valid); end
    n_checks++; if (stream_out_data !== 8'h11) begin n_fail++; $display("FAIL basic_data got %h exp 11", stream_out_data); end
    n_checks++; if (stream_out_last !== 1'b0) begin n_fail++; $display("FAIL basic_last got %b exp 0", stream_out_last); end
    tick();
    n_checks++; if (words_sent !== 16'd1) begin n_fail++; $display("FAIL basic_words got %0d exp 1", words_sent); end
    n_checks++; if (stream_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b exp 0", stream_out_valid); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL basic_level_end got %0d exp 0", fifo_level); end
  endtask

  task automatic test_full();
    int  idx;
    logic wr_fire;
    do_reset();
    tx_enable = 1'b1; stream_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'hA0 + 8'(i);
      n_checks++; if (wr_ready !== (i < 4)) begin n_fail++; $display("FAIL full_wr_ready_%0d got %b exp %b", i, wr_ready, (i < 4)); end
      tick();
    end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level got %0d exp 4", fifo_level); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready got %b exp 0", wr_ready); end
    n_checks++; if (stream_out_data !== 8'hA0) begin n_fail++; $display("FAIL full_head got %h exp a0", stream_out_data); end
    n_checks++; if (stream_out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b exp 1", stream_out_valid); end
    stream_out_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
      if (stream_out_valid) begin
        n_checks++; if (stream_out_data !== 8'hA0 + 8'(idx)) begin n_fail++; $display("FAIL full_order_%0d got %h exp %h", idx, stream_out_data, 8'hA0 + 8'(idx)); end
        idx++;
      end
      wr_fire = wr_valid && wr_ready;
      tick();
      if (wr_fire) wr_valid = 1'b0;
    end
    n_checks++; if (idx !== 5) begin n_fail++; $display("FAIL full_count got %0d exp 5", idx); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL full_drained got %0d exp 0", fifo_level); end
  endtask

  task automatic test_packet();
    int   wcnt;
    int   beats;
    logic wr_fire;
    do_reset();
    tx_enable = 1'b1; stream_out_ready = 1'b1;
    wcnt = 0; beats = 0;
    for (int cyc = 0; cyc < 30 && beats < 8; cyc++) begin
      wr_valid = (wcnt < 8);
      wr_data  = 8'h30 + 8'(wcnt);
      if (stream_out_valid) begin
        beats++;
        n_checks++; if (stream_out_last !== (beats % 4 == 0)) begin n_fail++; $display("FAIL pkt_last_beat%0d got %b exp %b", beats, stream_out_last, (beats % 4 == 0)); end
        n_checks++; if (stream_out_data !== 8'h30 + 8'(beats - 1)) begin n_fail++; $display("FAIL pkt_data_beat%0d got %h exp %h", beats, stream_out_data, 8'h30 + 8'(beats - 1)); end
      end
      wr_fire = wr_valid && wr_ready;
      tick();
      if (wr_fire) wcnt++;
    end
    wr_valid = 1'b0;
    n_checks++; if (beats !== 8) begin n_fail++; $display("FAIL pkt_beats got %0d exp 8", beats); end
    n_checks++; if (words_sent !== 16'd8) begin n_fail++; $display("FAIL pkt_words got %0d exp 8", words_sent); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    tx_enable = 1'b1; stream_out_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hB0;
    tick();
    wr_data = 8'hB1;
    tick();
    wr_valid = 1'b0;
    tx_enable = 1'b0;
    tick();
    tick();
    n_checks++; if (stream_out_valid !== 1'b1) begin n_fail++; $display("FAIL drop_valid_held got %b exp 1", stream_out_valid); end
    n_checks++; if (stream_out_data !== 8'hB0) begin n_fail++; $display("FAIL drop_data_held got %h exp b0", stream_out_data); end
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL drop_level got %0d exp 2", fifo_level); end
    stream_out_ready = 1'b1;
    tick();
    n_checks++; if (stream_out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_idle got %b exp 0", stream_out_valid); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL drop_level_after got %0d exp 1", fifo_level); end
    n_checks++; if (words_sent !== 16'd1) begin n_fail++; $display("FAIL drop_words got %0d exp 1", words_sent); end
    tick();
    n_checks++; if (stream_out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_stay_idle got %b exp 0", stream_out_valid); end
  endtask

  task automatic test_reset_mid();
    logic found;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 8'hD0 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    tx_enable = 1'b1; stream_out_ready = 1'b1;
    tick();
    tick();
    wr_valid = 1'b1; wr_data = 8'hD4;
    tick();
    wr_valid = 1'b0; stream_out_ready = 1'b0;
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL mid_level_pre got %0d exp 3", fifo_level); end
    n_checks++; if (words_sent !== 16'd2) begin n_fail++; $display("FAIL mid_words_pre got %0d exp 2", words_sent); end
    n_checks++; if (stream_out_data !== 8'hD2) begin n_fail++; $display("FAIL mid_head_pre got %h exp d2", stream_out_data); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (stream_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", stream_out_valid); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
    n_checks++; if (words_sent !== 16'd0) begin n_fail++; $display("FAIL mid_words got %0d exp 0", words_sent); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_wr_ready got %b exp 1", wr_ready); end
    #2 reset = 1'b0;
    tx_enable = 1'b1; stream_out_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 8'hE0;
    tick();
    wr_valid = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      if (stream_out_valid) begin
        found = 1'b1;
        n_checks++; if (stream_out_data !== 8'hE0) begin n_fail++; $display("FAIL mid_new_data got %h exp e0", stream_out_data); end
        n_checks++; if (stream_out_last !== 1'b0) begin n_fail++; $display("FAIL mid_new_last got %b exp 0", stream_out_last); end
      end
      tick();
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_new_timeout got %b exp 1", found); end
    n_checks++; if (words_sent !== 16'd1) begin n_fail++; $display("FAIL mid_new_words got %0d exp 1", words_sent); end
  endtask

  task automatic test_wrap();
    int   wcnt;
    int   rcnt;
    int   errs;
    logic seen_max;
    logic wr_fire;
    logic pop;
    do_reset();
    tx_enable = 1'b1; stream_out_ready = 1'b1;
    wcnt = 0; rcnt = 0; errs = 0; seen_max = 1'b0;
    for (int cyc = 0; cyc < 70000 && rcnt < 65536; cyc++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(wcnt);
      if (rcnt == 65535 && !seen_max) begin
        seen_max = 1'b1;
        n_checks++; if (words_sent !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got %h exp ffff", words_sent); end
      end
      pop = stream_out_valid && stream_out_ready;
      if (pop && stream_out_data !== 8'(rcnt)) errs++;
      wr_fire = wr_valid && wr_ready;
      tick();
      if (wr_fire) wcnt++;
      if (pop) rcnt++;
    end
    wr_valid = 1'b0;
    n_checks++; if (rcnt !== 65536) begin n_fail++; $display("FAIL wrap_count got %0d exp 65536", rcnt); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL wrap_order got %0d bad beats exp 0", errs); end
    n_checks++; if (words_sent !== 16'h0000) begin n_fail++; $display("FAIL wrap_words got %h exp 0000", words_sent); end
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    tx_enable = 1'b0; stream_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_packet();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
